spi_master: RTL

//  Host-side SPI initiator that drives our 10-bit-frame SPI slave protocol. Accepts a 10-bit

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_frame_shifter.sv | 66 ++++++
 rtl/spi_master.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: opcodes, FSM state encoding and frame-size defaults.
// Used by spi_master and spi_frame_shifter; the slave imports the same opcodes.
package spi_pkg;

    localparam int FRAME_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;
    localparam int RD_WAIT_DEF = 2;
    localparam int GAP_CYC_DEF = 1;

    // Wide enough for the longest per-state count (GAP_CYC up to 15)
    localparam int CNT_W = 5;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        CMD   = 3'd2,
        SHIFT = 3'd3,
        WAIT  = 3'd4,
        READ  = 3'd5,
        GAP   = 3'd6
    } spi_state_e;

    function automatic logic [1:0] cmd_opcode(input logic [FRAME_W_DEF-1:0] cmd);
        return cmd[FRAME_W_DEF-1 -: 2];
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Datapath for spi_master: MOSI load/shift-out register, MISO shift-in register and a
// per-state cycle counter that saturates at a programmable terminal value.
module spi_frame_shifter
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic               sample,
    input  logic               cnt_clr,
    input  logic [FRAME_W-1:0] load_data,
    input  logic [CNT_W-1:0]   cnt_term,
    input  logic               miso,
    output logic               tx_msb,
    output logic [DATA_W-1:0]  rx_next,
    output logic               cnt_done
);

    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign tx_msb   = tx_q[FRAME_W-1];
    assign rx_next  = {rx_q[DATA_W-2:0], miso};
    assign cnt_done = (cnt_q == cnt_term);

    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        cnt_d = cnt_q;

        if (load) begin
            tx_d = load_data;
        end else if (shift) begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        end

        if (sample) begin
            rx_d = rx_next;
        end

        // Clear wins so every state starts counting from zero; hold once terminal
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (!cnt_done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q  <= '0;
            rx_q  <= '0;
            cnt_q <= '0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI initiator for the 10-bit-frame slave protocol: frames commands on SS_n/MOSI and
// captures read replies from MISO. Optional sequence check: SPI_MASTER_SEQ_CHECK_EN.
module spi_master
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FRAME_W-1:0] cmd_data,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic               busy,
    output logic               cmd_err,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

    spi_state_e        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              accept;
    logic              reject;
    logic              load;
    logic              shift;
    logic              sample;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt_term;
    logic              tx_msb;
    logic [DATA_W-1:0] rx_next;
    logic              cnt_done;

    assign accept = cmd_valid && cmd_ready_q;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic addr_loaded_q, addr_loaded_d;
    logic cmd_err_q, cmd_err_d;

    // A read-data frame is only meaningful after a read-address frame has completed
    assign reject  = accept && (cmd_opcode(cmd_data) == OP_RD_DATA) && !addr_loaded_q;
    assign cmd_err = cmd_err_q;
`else
    assign reject  = 1'b0;
    assign cmd_err = 1'b0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

    always_comb begin
        cnt_term = '0;
        case (state_q)
            SHIFT:   cnt_term = SHIFT_LAST;
            WAIT:    cnt_term = WAIT_LAST;
            READ:    cnt_term = READ_LAST;
            GAP:     cnt_term = GAP_LAST;
            default: cnt_term = '0;
        endcase
    end

    assign cnt_clr = (state_d != state_q);

    // Next-state and next-output logic; every output below is registered
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ss_n_d      = ss_n_q;
        mosi_d      = 1'b0;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        load        = 1'b0;
        shift       = 1'b0;
        sample      = 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
        addr_loaded_d = addr_loaded_q;
        cmd_err_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d        = cmd_opcode(cmd_data);
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (reject) begin
`ifdef SPI_MASTER_SEQ_CHECK_EN
                        cmd_err_d = 1'b1;
`endif
                        state_d = GAP;
                    end else begin
                        load    = 1'b1;
                        ss_n_d  = 1'b0;
                        state_d = SEL;
                    end
                end
            end
            SEL: begin
                mosi_d  = tx_msb;
                state_d = CMD;
            end
            CMD: begin
                mosi_d  = tx_msb;
                shift   = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_done) begin
                    case (op_q)
                        OP_RD_DATA: begin
                            state_d = WAIT;
                        end
                        OP_RD_ADDR: begin
`ifdef SPI_MASTER_SEQ_CHECK_EN
                            addr_loaded_d = 1'b1;
`endif
                            ss_n_d  = 1'b1;
                            state_d = GAP;
                        end
                        OP_WR_ADDR, OP_WR_DATA: begin
                            ss_n_d  = 1'b1;
                            state_d = GAP;
                        end
                        default: begin
                            ss_n_d  = 1'b1;
                            state_d = GAP;
                        end
                    endcase
                end else begin
                    mosi_d = tx_msb;
                    shift  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_done) begin
                    state_d = READ;
                end
            end
            READ: begin
                sample = 1'b1;
                // rx_next already includes this cycle's MISO bit, so the byte is complete
                if (cnt_done) begin
                    rd_data_d  = rx_next;
                    rd_valid_d = 1'b1;
                    ss_n_d     = 1'b1;
                    state_d    = GAP;
`ifdef SPI_MASTER_SEQ_CHECK_EN
                    addr_loaded_d = 1'b0;
`endif
                end
            end
            GAP: begin
                if (cnt_done) begin
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                ss_n_d      = 1'b1;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_WR_ADDR;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

`ifdef SPI_MASTER_SEQ_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_loaded_q <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            addr_loaded_q <= addr_loaded_d;
            cmd_err_q     <= cmd_err_d;
        end
    end
`endif

    spi_frame_shifter #(
        .FRAME_W(FRAME_W),
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .sample   (sample),
        .cnt_clr  (cnt_clr),
        .load_data(cmd_data),
        .cnt_term (cnt_term),
        .miso     (MISO),
        .tx_msb   (tx_msb),
        .rx_next  (rx_next),
        .cnt_done (cnt_done)
    );

endmodule
